pmem_stream_loader: RTL and testbench

//  Parametrised program memory with a streaming loader. Replaces the fixed 256x12 store
//  and its per-word address load port with three features:
//   - a valid/ready burst loader that auto-increments from a base address
//   - a registered fetch port with a valid flag
//   - an XOR checksum over each loaded burst

---
 rtl/pmem_pkg.sv | 13 +
 rtl/pmem_array.sv | 32 +++
 rtl/pmem_stream_loader.sv | 131 +++++++++++++
 tb/tb_pmem_stream_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types and default geometry for the streaming-loaded program memory.
package pmem_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pmem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one synchronous read port.
module pmem_array #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents and read register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pmem_stream_loader.sv
// Program memory with a valid/ready burst loader, XOR burst checksum and a
// registered fetch port that is blocked while a burst is in progress.
module pmem_stream_loader
  import pmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              load_abort,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [DATA_W-1:0] load_csum
);

  localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              valid_q, valid_d;

  logic              mem_we;
  logic              fetch_re;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      csum_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      csum_q  <= csum_d;
      valid_q <= valid_d;
    end
  end

  // The checksum is published on entry to DONE so it is already valid
  // while load_done is high, and then holds until the next completed burst.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    csum_d  = csum_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          ptr_d = load_base;
          rem_d = load_count;
          acc_d = '0;
          if (load_count == '0) begin
            csum_d  = '0;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_ONE;
          rem_d  = rem_q - REM_ONE;
          acc_d  = acc_q ^ load_data;
          if (rem_q == REM_ONE) begin
            csum_d  = acc_q ^ load_data;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready = (state_q == LOAD);
  assign load_busy  = (state_q != IDLE);
  assign load_done  = (state_q == DONE);
  assign load_csum  = csum_q;

  assign fetch_re = en & ~load_busy;
  assign valid_d  = fetch_re;

  // The read register only updates on a fetch; gating with the valid flag
  // yields the required zero output on non-fetch cycles and after reset.
  assign instr       = valid_q ? rdata : '0;
  assign instr_valid = valid_q;

  pmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr_q),
    .wdata (load_data),
    .re    (fetch_re),
    .raddr (addr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_pmem_stream_loader.sv
// Directed/randomized bench for pmem_stream_loader against an array-based memory model.
module tb_pmem_stream_loader;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [AW-1:0] addr;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_count;
  logic          load_abort;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;
  logic [DW-1:0] load_csum;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] csum_m;
  logic [DW-1:0] dq[$];
  bit            vq[$];

  pmem_stream_loader #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .addr        (addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .load_abort  (load_abort),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_csum   (load_csum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input int a);
    addr = AW'(a);
    en   = 1'b1;
    tick();
    en   = 1'b0;
    chk("fetch_instr", 32'(instr), 32'(mem_m[a % DEPTH]));
    chk("fetch_valid", 32'(instr_valid), 1);
  endtask

  // abort_at < 0 means no abort; poke_start re-asserts load_start mid-burst.
  task automatic burst(input int base, input int count, input bit gaps,
                       input int abort_at, input bit poke_start);
    logic [DW-1:0] acc;
    logic [DW-1:0] w;
    bit            v;
    int            n;
    int            ptr;
    int            budget;
    acc = '0; n = 0; ptr = base; budget = 0;
    load_base  = AW'(base);
    load_count = (AW+1)'(count);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    if (count == 0) begin
      chk("zero_done", 32'(load_done), 1);
      chk("zero_csum", 32'(load_csum), 0);
      chk("zero_ready", 32'(load_ready), 0);
      tick();
      chk("zero_done_end", 32'(load_done), 0);
      chk("zero_busy_end", 32'(load_busy), 0);
      csum_m = '0;
      return;
    end
    en   = 1'b1;
    addr = AW'($urandom);
    while (n < count) begin
      chk("ld_ready", 32'(load_ready), 1);
      chk("ld_gate", 32'({instr_valid, instr}), 0);
      budget++;
      if (budget > 3000) begin
        chk("burst_budget", 32'(budget), 0);
        break;
      end
      if (n == abort_at) begin
        load_abort = 1'b1;
        load_valid = 1'b1;
        load_data  = DW'($urandom);
        tick();
        load_abort = 1'b0;
        load_valid = 1'b0;
        en = 1'b0;
        chk("abort_busy", 32'(load_busy), 0);
        chk("abort_done", 32'(load_done), 0);
        chk("abort_csum", 32'(load_csum), 32'(csum_m));
        return;
      end
      if (poke_start && n == 1) begin
        load_start = 1'b1;
        load_base  = AW'(base + 8'h33);
        load_count = 1;
      end
      v = (vq.size() != 0) ? vq.pop_front() : (gaps ? bit'($urandom_range(0, 1)) : 1'b1);
      w = (dq.size() != 0) ? dq.pop_front() : DW'($urandom);
      load_valid = v;
      load_data  = w;
      tick();
      load_start = 1'b0;
      if (v) begin
        mem_m[ptr % DEPTH] = w;
        acc = acc ^ w;
        ptr++;
        n++;
      end
      if (n < count) chk("done_early", 32'(load_done), 0);
    end
    load_valid = 1'b0;
    chk("done_pulse", 32'(load_done), 1);
    chk("done_csum", 32'(load_csum), 32'(acc));
    chk("done_busy", 32'(load_busy), 1);
    chk("done_ready", 32'(load_ready), 0);
    csum_m = acc;
    tick();
    en = 1'b0;
    chk("done_end", 32'(load_done), 0);
    chk("idle_busy", 32'(load_busy), 0);
    chk("csum_hold", 32'(load_csum), 32'(csum_m));
    chk("gate_done_edge", 32'(instr_valid), 0);
  endtask

  initial begin
    logic [DW-1:0] w0;
    rst_n = 1'b0; en = 1'b0; addr = '0; load_start = 1'b0; load_base = '0;
    load_count = '0; load_abort = 1'b0; load_valid = 1'b0; load_data = '0;
    csum_m = '0;
    tick();
    tick();
    chk("rst_outs", 32'({instr, instr_valid, load_ready, load_busy, load_done, load_csum}), 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(load_ready), 0);

    // Fill the entire memory so every later fetch has a known expectation.
    burst(0, DEPTH, 1'b1, -1, 1'b0);
    for (int i = 0; i < 6; i++) fetch(int'($urandom_range(0, DEPTH - 1)));
    tick();
    chk("fetch_idle_clear", 32'({instr_valid, instr}), 0);

    dq = '{12'h111, 12'h222, 12'h444};
    burst(8'h10, 3, 1'b0, -1, 1'b0);
    chk("csum_777", 32'(load_csum), 32'h777);
    fetch(8'h11);
    chk("instr_222", 32'(instr), 32'h222);

    burst(8'hFE, 3, 1'b0, -1, 1'b0);
    fetch(8'hFE); fetch(8'hFF); fetch(8'h00);

    vq = '{1'b1, 1'b0, 1'b0, 1'b1};
    burst(8'h30, 2, 1'b0, -1, 1'b0);
    fetch(8'h30); fetch(8'h31); fetch(8'h32);

    burst(8'h40, 4, 1'b0, 2, 1'b0);
    fetch(8'h40); fetch(8'h41); fetch(8'h42); fetch(8'h43);

    burst(8'h50, 0, 1'b0, -1, 1'b0);
    fetch(8'h50);

    burst(8'h70, 4, 1'b0, -1, 1'b1);
    for (int a = 8'h70; a < 8'h74; a++) fetch(a);
    fetch(8'hA3); fetch(8'hA4);

    burst(8'h80, 260, 1'b1, -1, 1'b0);
    for (int i = 0; i < 8; i++) fetch(int'($urandom_range(0, DEPTH - 1)));
    fetch(8'h80); fetch(8'h83);

    // Asynchronous reset in the middle of a burst.
    load_base = 8'h60; load_count = 5; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    w0 = DW'($urandom);
    load_valid = 1'b1; load_data = w0;
    tick();
    mem_m[8'h60] = w0;
    load_valid = 1'b0;
    chk("pre_rst_busy", 32'(load_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({instr, instr_valid, load_ready, load_busy, load_done, load_csum}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    csum_m = '0;
    chk("rel_ready", 32'(load_ready), 0);
    chk("rel_valid", 32'(instr_valid), 0);
    fetch(8'h60); fetch(8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
